alu: RTL and testbench
======================

# alu

Combinational 32-bit integer ALU for the execute stage of the pipelined RV32I datapath, with an optional registered copy of its result for the EX/MEM boundary. `aluOp` selects one of ten RV32I operations using the encoding {funct7[5], funct3}. The combinational result is valid within the same cycle with no clock involvement. The registered outputs give the pipeline a clean stage boundary.

## Interface
- No parameters; data width fixed at 32.
- `clk`  in  1  single clock; rising-edge active; drives only the output register.
- `rst`  in  1  synchronous, active-high reset; clears the output register.
- `en`  in  1  output-register load enable; when low, the register holds its value.
- `A`  in  32  operand 1 (rs1 or PC).
- `B`  in  32  operand 2 (rs2 or immediate).
- `aluOp`  in  4  operation select: {funct7[5], funct3}.
- `aluRes`  out  32  combinational result.
- `zero`  out  1  combinational; high when `aluRes` is 0.
- `aluResQ`  out  32  registered `aluRes`.
- `zeroQ`  out  1  registered `zero`.

## Operation
- 0000 ADD: A+B, modulo 2^32; carry discarded.
- 1000 SUB: A−B, modulo 2^32.
- 0001 SLL: A << B[4:0].
- 0010 SLT: {31'b0, signed(A) < signed(B)}.
- 0011 SLTU: {31'b0, A < B}, unsigned compare.
- 0100 XOR: A ^ B.
- 0101 SRL: A >> B[4:0], zero fill.
- 1101 SRA: A >>> B[4:0], sign fill from A[31].
- 0110 OR: A | B.
- 0111 AND: A & B.
- All other codes (1001, 1010, 1011, 1100, 1110, 1111): `aluRes` = 0 and `zero` = 1.
- Shift amount uses only B[4:0]; B[31:5] is ignored.
- No overflow or carry outputs; no exceptions are raised.
- `zero` = (aluRes == 32'h0).

## Timing
- `aluRes` and `zero` are purely combinational from `A`, `B` and `aluOp`, with zero-cycle latency. They must be correct with `clk` idle or `rst` asserted.
- Register update on rising `clk`, in priority order:
  - `rst`=1: `aluResQ` = 0 and `zeroQ` = 1.
  - else `en`=1: load `aluRes` and `zero`.
  - else hold.
- Reset values: `aluResQ` = 32'h0, `zeroQ` = 1.
- `rst` and `en` asserted together: reset wins.
- Registered outputs have 1-cycle latency.
- Reset mid-operation clears only the register; the combinational path is unaffected.

## Structure
- Shared package `alu_pkg`:
  - enum `alu_op_e` (4-bit) with constants ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND at the encodings listed under Operation.
  - `XLEN` = 32.
  - The decoder and control unit import the same package.
- Natural sub-module: `alu_shifter`, a 32-bit barrel shifter for SLL, SRL and SRA (inputs: data, shamt[4:0], dir, arith).
- Remaining logic: one combinational case statement plus the output register in `alu`.

## Test plan
- ADD: A=7, B=3, aluOp=0000 → aluRes=0000000a, zero=0. Also A=FFFFFFFF, B=1 → 00000000, zero=1 (wrap).
- SUB: A=7, B=3, aluOp=1000 → aluRes=00000004. Also A=3, B=7 → FFFFFFFC.
- Compares: A=FFFFFFFF, B=1. SLT → 00000001; SLTU → 00000000.
- Shifts: A=80000000, B=0000_0024 (shamt 4). SRL → 08000000; SRA → F8000000; SLL with A=1 → 00000010.
- Logic and illegal codes: A=F0F0F0F0, B=0FF00FF0. AND → 00F000F0; OR → FFF0FFF0; XOR → FF00FF00; aluOp=1111 → 00000000, zero=1.
- Register path:
  - `rst`=1 for 1 cycle → aluResQ=0, zeroQ=1.
  - ADD 7+3 with en=1 → aluResQ=0000000a one cycle later.
  - en=0 with new inputs → aluResQ holds 0000000a.
  - rst and en both high → aluResQ=0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU, the decoder and the control unit.
//   XLEN     : integer datapath width (32 for RV32I).
//   alu_op_e : 4-bit operation select, encoded as {funct7[5], funct3}, so the
//              decoder can form it straight from the instruction bits.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_e;

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: 32-bit barrel shifter used for SLL, SRL and SRA.
//   data   : value to shift
//   shamt  : shift amount, 0..31
//   dir    : 0 = shift left, 1 = shift right
//   arith  : on a right shift, 1 fills with data[31], 0 fills with zeros
//   result : shifted value
module alu_shifter
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] data,
  input  logic [4:0]      shamt,
  input  logic            dir,
  input  logic            arith,
  output logic [XLEN-1:0] result
);

  // Right shifts go through a 33-bit signed value whose extra top bit is the
  // fill bit; one arithmetic shift then covers both SRL (fill 0) and SRA.
  logic signed [XLEN:0] rightIn;
  logic signed [XLEN:0] rightOut;

  always_comb begin
    rightIn  = $signed({arith & data[XLEN-1], data});
    rightOut = rightIn >>> shamt;
    if (dir) begin
      result = rightOut[XLEN-1:0];
    end else begin
      result = data << shamt;
    end
  end

endmodule

// File: rtl/alu.sv
// alu: RV32I execute-stage integer ALU with a registered copy of its result.
//   clk     : rising-edge clock, used only by the output register
//   rst     : synchronous active-high reset of the output register
//   en      : output-register load enable (hold when low)
//   A, B    : operands (rs1/PC and rs2/immediate)
//   aluOp   : operation select {funct7[5], funct3}, see alu_pkg::alu_op_e
//   aluRes  : combinational result
//   zero    : combinational, high when aluRes is 0
//   aluResQ : registered aluRes (reset 0)
//   zeroQ   : registered zero (reset 1)
module alu
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [3:0]      aluOp,
  output logic [XLEN-1:0] aluRes,
  output logic            zero,
  output logic [XLEN-1:0] aluResQ,
  output logic            zeroQ
);

  logic [XLEN-1:0] shiftRes;
  logic            shiftDir;
  logic            shiftArith;

  // Direction and fill come straight from the opcode bits: funct3[2] marks
  // the right shifts, funct7[5] marks the arithmetic one.
  assign shiftDir   = aluOp[2];
  assign shiftArith = aluOp[3];

  alu_shifter u_shifter (
    .data   (A),
    .shamt  (B[4:0]),
    .dir    (shiftDir),
    .arith  (shiftArith),
    .result (shiftRes)
  );

  always_comb begin
    aluRes = '0;
    case (aluOp)
      ALU_ADD:  aluRes = A + B;
      ALU_SUB:  aluRes = A - B;
      ALU_SLL:  aluRes = shiftRes;
      ALU_SLT:  aluRes = {{(XLEN-1){1'b0}}, $signed(A) < $signed(B)};
      ALU_SLTU: aluRes = {{(XLEN-1){1'b0}}, A < B};
      ALU_XOR:  aluRes = A ^ B;
      ALU_SRL:  aluRes = shiftRes;
      ALU_SRA:  aluRes = shiftRes;
      ALU_OR:   aluRes = A | B;
      ALU_AND:  aluRes = A & B;
      // Unused encodings yield 0 so zero reads high.
      default:  aluRes = '0;
    endcase
  end

  assign zero = (aluRes == '0);

  // Reset takes priority over load enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      aluResQ <= '0;
      zeroQ   <= 1'b1;
    end else if (en) begin
      aluResQ <= aluRes;
      zeroQ   <= zero;
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed-vector bench for alu. The driver applies a vector just
// after a rising edge and pushes the hand-computed expectation; the monitor
// pops and compares on the following falling edge.
module tb_alu;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         en;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   alu_op;
  logic [W-1:0] alu_res;
  logic         zero;
  logic [W-1:0] alu_res_q;
  logic         zero_q;

  // Scoreboard: expected value, expected zero flag, kind (0 comb, 1 reg), tag.
  logic [W-1:0] exp_q[$];
  logic         exp_zero_q[$];
  logic         exp_kind_q[$];
  int           exp_tag_q[$];

  int checks   = 0;
  int failures = 0;
  bit drv_done = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .A       (a),
    .B       (b),
    .aluOp   (alu_op),
    .aluRes  (alu_res),
    .zero    (zero),
    .aluResQ (alu_res_q),
    .zeroQ   (zero_q)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic kind, input logic [W-1:0] res,
                          input logic z, input int tag);
    exp_q.push_back(res);
    exp_zero_q.push_back(z);
    exp_kind_q.push_back(kind);
    exp_tag_q.push_back(tag);
  endtask

  task automatic drive_comb(input logic [W-1:0] va, input logic [W-1:0] vb,
                            input logic [3:0] op, input logic [W-1:0] res,
                            input logic z, input int tag);
    a      = va;
    b      = vb;
    alu_op = op;
    push_exp(1'b0, res, z, tag);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [W-1:0] er;
      logic         ez;
      logic         ek;
      int           et;
      logic [W-1:0] ar;
      logic         az;
      er = exp_q.pop_front();
      ez = exp_zero_q.pop_front();
      ek = exp_kind_q.pop_front();
      et = exp_tag_q.pop_front();
      ar = ek ? alu_res_q : alu_res;
      az = ek ? zero_q : zero;
      checks++;
      if (ar !== er) begin
        failures++;
        $display("FAIL %s_res vec%0d: got %08h expected %08h",
                 ek ? "reg" : "comb", et, ar, er);
      end
      checks++;
      if (az !== ez) begin
        failures++;
        $display("FAIL %s_zero vec%0d: got %0b expected %0b",
                 ek ? "reg" : "comb", et, az, ez);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    a      = '0;
    b      = '0;
    alu_op = 4'b0000;

    // Reset edge; register must show reset values, comb path still works.
    step();
    drive_comb(32'd7, 32'd3, 4'b0000, 32'h0000000a, 1'b0, 0);
    push_exp(1'b1, 32'h0, 1'b1, 100);

    step();
    rst = 1'b0;
    drive_comb(32'hffffffff, 32'd1,        4'b0000, 32'h00000000, 1'b1, 1);
    step(); drive_comb(32'd7,        32'd3,        4'b1000, 32'h00000004, 1'b0, 2);
    step(); drive_comb(32'd3,        32'd7,        4'b1000, 32'hfffffffc, 1'b0, 3);
    step(); drive_comb(32'hffffffff, 32'd1,        4'b0010, 32'h00000001, 1'b0, 4);
    step(); drive_comb(32'hffffffff, 32'd1,        4'b0011, 32'h00000000, 1'b1, 5);
    step(); drive_comb(32'h80000000, 32'h00000024, 4'b0101, 32'h08000000, 1'b0, 6);
    step(); drive_comb(32'h80000000, 32'h00000024, 4'b1101, 32'hf8000000, 1'b0, 7);
    step(); drive_comb(32'h00000001, 32'h00000024, 4'b0001, 32'h00000010, 1'b0, 8);
    step(); drive_comb(32'h40000000, 32'h00000024, 4'b1101, 32'h04000000, 1'b0, 9);
    step(); drive_comb(32'hf0f0f0f0, 32'h0ff00ff0, 4'b0111, 32'h00f000f0, 1'b0, 10);
    step(); drive_comb(32'hf0f0f0f0, 32'h0ff00ff0, 4'b0110, 32'hfff0fff0, 1'b0, 11);
    step(); drive_comb(32'hf0f0f0f0, 32'h0ff00ff0, 4'b0100, 32'hff00ff00, 1'b0, 12);
    step(); drive_comb(32'hf0f0f0f0, 32'h0ff00ff0, 4'b1111, 32'h00000000, 1'b1, 13);
    step(); drive_comb(32'd7,        32'd3,        4'b1001, 32'h00000000, 1'b1, 14);
    // Register never loaded since reset (en low throughout).
    push_exp(1'b1, 32'h0, 1'b1, 101);

    // Load ADD 7+3.
    step();
    en = 1'b1;
    drive_comb(32'd7, 32'd3, 4'b0000, 32'h0000000a, 1'b0, 15);
    step();
    push_exp(1'b1, 32'h0000000a, 1'b0, 102);
    // Hold with new inputs.
    en = 1'b0;
    drive_comb(32'd1, 32'd1, 4'b0000, 32'h00000002, 1'b0, 16);
    step();
    push_exp(1'b1, 32'h0000000a, 1'b0, 103);
    // Reset and enable together: reset wins.
    rst = 1'b1;
    en  = 1'b1;
    step();
    push_exp(1'b1, 32'h00000000, 1'b1, 104);
    // Comb path unaffected while reset held.
    drive_comb(32'h0000000f, 32'h00000003, 4'b0101, 32'h00000001, 1'b0, 17);
    step();
    rst = 1'b0;
    en  = 1'b0;
    drive_done_mark();
  end

  task automatic drive_done_mark();
    drv_done = 1'b1;
  endtask

  // ---------------- final report ----------------
  initial begin
    fork
      wait (drv_done);
      begin
        #100000;
        failures++;
        $display("FAIL timeout: driver did not finish, got running expected done");
      end
    join_any
    disable fork;
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
